// File: rtl/rotary_input_bank.sv
// rotary_input_bank: a bank of quadrature rotary-encoder decoders. Each channel has
// its own push-button debounce and a signed position counter.
// Build option: define QUAD_LONGPRESS_EN to add per-channel long-press detection.
// Without it, longPress is tied low and no long counters are built.
module rotary_input_bank #(
    parameter int CHANNELS      = 1,
    parameter int DEBOUNCE_BITS = 16,
    parameter int COUNT_WIDTH   = 8,
    parameter int LONG_BITS     = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             rotA,
    input  logic [CHANNELS-1:0]             rotB,
    input  logic [CHANNELS-1:0]             rotCenter,
    input  logic [CHANNELS-1:0]             posClear,
    output logic [CHANNELS-1:0]             left,
    output logic [CHANNELS-1:0]             right,
    output logic [CHANNELS-1:0]             down,
    output logic [CHANNELS-1:0]             up,
    output logic [CHANNELS-1:0]             held,
    output logic [CHANNELS-1:0]             longPress,
    output logic [CHANNELS*COUNT_WIDTH-1:0] position
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } btnState_t;

    localparam logic [COUNT_WIDTH-1:0]   posOne = COUNT_WIDTH'(1);
    localparam logic [DEBOUNCE_BITS-1:0] dbOne  = DEBOUNCE_BITS'(1);

    logic [CHANNELS-1:0] aMeta, aSync;
    logic [CHANNELS-1:0] bMeta, bSync;
    logic [CHANNELS-1:0] cMeta, cSync;

    // Two-flop synchronizers. The encoder phases idle high and the button idles low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aMeta <= '1;
            aSync <= '1;
            bMeta <= '1;
            bSync <= '1;
            cMeta <= '0;
            cSync <= '0;
        end else begin
            aMeta <= rotA;
            aSync <= aMeta;
            bMeta <= rotB;
            bSync <= bMeta;
            cMeta <= rotCenter;
            cSync <= cMeta;
        end
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : gChan
            logic                     q1, q2, q1Delay;
            logic                     leftR, rightR;
            logic [COUNT_WIDTH-1:0]   posR;
            btnState_t                state;
            logic [DEBOUNCE_BITS-1:0] cnt;
            logic                     downR, upR, heldR;

            // Rotary filter and step decode. A rising q1 marks a detent, and q2 gives the direction.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q1      <= 1'b1;
                    q2      <= 1'b0;
                    q1Delay <= 1'b1;
                    leftR   <= 1'b0;
                    rightR  <= 1'b0;
                end else begin
                    case ({bSync[i], aSync[i]})
                        2'b00:   q1 <= 1'b0;
                        2'b11:   q1 <= 1'b1;
                        2'b01:   q2 <= 1'b0;
                        default: q2 <= 1'b1;
                    endcase
                    q1Delay <= q1;
                    rightR  <= q1 & ~q1Delay & q2;
                    leftR   <= q1 & ~q1Delay & ~q2;
                end
            end

            // Position counter. It wraps in two's complement, and a clear wins over a same-cycle step.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    posR <= '0;
                end else if (posClear[i]) begin
                    posR <= '0;
                end else if (rightR) begin
                    posR <= posR + posOne;
                end else if (leftR) begin
                    posR <= posR - posOne;
                end
            end

            // Button debounce FSM. A press must stay high for the full count; release is taken at once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= IDLE;
                    cnt   <= '0;
                    downR <= 1'b0;
                    upR   <= 1'b0;
                    heldR <= 1'b0;
                end else begin
                    downR <= 1'b0;
                    upR   <= 1'b0;
                    case (state)
                        IDLE: begin
                            if (cSync[i]) begin
                                state <= COUNT;
                                cnt   <= dbOne;
                            end
                        end
                        COUNT: begin
                            if (!cSync[i]) begin
                                state <= IDLE;
                                cnt   <= '0;
                            end else if (cnt == '1) begin
                                state <= HELD;
                                downR <= 1'b1;
                                heldR <= 1'b1;
                            end else begin
                                cnt <= cnt + dbOne;
                            end
                        end
                        HELD: begin
                            if (!cSync[i]) begin
                                state <= IDLE;
                                upR   <= 1'b1;
                                heldR <= 1'b0;
                                cnt   <= '0;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            cnt   <= '0;
                            heldR <= 1'b0;
                        end
                    endcase
                end
            end

`ifdef QUAD_LONGPRESS_EN
            logic [LONG_BITS-1:0] longCnt;
            logic                 longR;

            // Long-press timer. It runs only while held, saturates at all-ones and pulses once on arrival.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    longCnt <= '0;
                    longR   <= 1'b0;
                end else begin
                    longR <= 1'b0;
                    if (state != HELD) begin
                        longCnt <= '0;
                    end else if (longCnt != '1) begin
                        longCnt <= longCnt + LONG_BITS'(1);
                        if (longCnt == {{(LONG_BITS-1){1'b1}}, 1'b0}) begin
                            longR <= 1'b1;
                        end
                    end
                end
            end

            assign longPress[i] = longR;
`endif

            assign left[i]  = leftR;
            assign right[i] = rightR;
            assign down[i]  = downR;
            assign up[i]    = upR;
            assign held[i]  = heldR;
            assign position[i*COUNT_WIDTH +: COUNT_WIDTH] = posR;
        end
    endgenerate

`ifndef QUAD_LONGPRESS_EN
    // LONG_BITS only sizes the long-press timers, so here it just qualifies a constant-zero output.
    assign longPress = {CHANNELS{1'b0}} & {CHANNELS{LONG_BITS > 0}};
`endif

endmodule
